// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler for the 5-stage core: stall/flush controls, EX forwarding selects,
// data-memory wait sequencing with a timeout watchdog, and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_addrD,
  input  logic [4:0]       rs2_addrD,
  input  logic [4:0]       rs1_addrE,
  input  logic [4:0]       rs2_addrE,
  input  logic [4:0]       rdE,
  input  logic             RegWriteE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic [4:0]       rdM,
  input  logic             RegWriteM,
  input  logic [4:0]       rdW,
  input  logic             RegWriteW,
  input  logic             mem_reqM,
  input  logic             mem_readyM,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             ID_EX_Flush,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_MEMWAIT = 2'd1;
  localparam logic [1:0] S_ERROR   = 2'd2;
  localparam logic [7:0] TIMEOUT   = MEM_TIMEOUT[7:0];

  logic [1:0] state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       memstall, loaduse;

  assign memstall  = mem_reqM & ~mem_readyM;
  assign loaduse   = MemReadE & RegWriteE & (rdE != 5'd0) &
                     ((rdE == rs1_addrD) | (rdE == rs2_addrD));
  assign state_dbg = state;

  // Priority: ERROR freeze, memory stall, taken branch, load-use bubble.
  always_comb begin
    StallF      = 1'b0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    ID_EX_Flush = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushW      = 1'b0;
    if (state == S_ERROR || memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD      = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (loaduse) begin
      StallF      = 1'b1;
      StallD      = 1'b1;
      ID_EX_Flush = 1'b1;
    end
  end

  // MEM result is younger than WB, so it wins when both match.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && rdM != 5'd0 && rdM == rs1_addrE)      ForwardAE = 2'b10;
    else if (RegWriteW && rdW != 5'd0 && rdW == rs1_addrE) ForwardAE = 2'b01;
    if (RegWriteM && rdM != 5'd0 && rdM == rs2_addrE)      ForwardBE = 2'b10;
    else if (RegWriteW && rdW != 5'd0 && rdW == rs2_addrE) ForwardBE = 2'b01;
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      S_RUN: begin
        if (memstall) begin
          wait_nxt  = 8'd1;
          state_nxt = (TIMEOUT == 8'd1) ? S_ERROR : S_MEMWAIT;
        end
      end
      S_MEMWAIT: begin
        if (!memstall) begin
          wait_nxt  = 8'd0;
          state_nxt = S_RUN;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
          if (wait_nxt == TIMEOUT) state_nxt = S_ERROR;
        end
      end
      S_ERROR: state_nxt = S_ERROR;
      default: begin
        state_nxt = S_RUN;
        wait_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      wait_cnt     <= 8'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_nxt == S_ERROR) mem_timeout <= 1'b1;
      if (StallF && stall_cycles != {CNT_W{1'b1}}) stall_cycles <= stall_cycles + 1'b1;
      if (ID_EX_Flush && flush_count != {CNT_W{1'b1}}) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vectors for pipeline_hazard_ctrl; expected outputs queued at issue time and
// checked by an independent negedge monitor.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int W     = 7 + 2 + 2 + 1 + CNT_W + CNT_W;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rdE, rdM, rdW;
  logic RegWriteE, MemReadE, PCSrcE, RegWriteM, RegWriteW, mem_reqM, mem_readyM;
  logic StallF, StallD, FlushD, ID_EX_Flush, StallE, StallM, FlushW, mem_timeout;
  logic [1:0] ForwardAE, ForwardBE, state_dbg;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  logic [CNT_W-1:0] exp_sc, exp_fc;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_LU    = 7'b1101000;  // StallF StallD ID_EX_Flush
  localparam logic [6:0] C_BR    = 7'b0011000;  // FlushD ID_EX_Flush
  localparam logic [6:0] C_FREEZE = 7'b1100111; // StallF StallD StallE StallM FlushW

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_addrD(rs1_addrD), .rs2_addrD(rs2_addrD),
    .rs1_addrE(rs1_addrE), .rs2_addrE(rs2_addrE),
    .rdE(rdE), .RegWriteE(RegWriteE), .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .rdM(rdM), .RegWriteM(RegWriteM), .rdW(rdW), .RegWriteW(RegWriteW),
    .mem_reqM(mem_reqM), .mem_readyM(mem_readyM),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .ID_EX_Flush(ID_EX_Flush),
    .StallE(StallE), .StallM(StallM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic zero_inputs();
    rs1_addrD = 5'd0; rs2_addrD = 5'd0; rs1_addrE = 5'd0; rs2_addrE = 5'd0;
    rdE = 5'd0; RegWriteE = 1'b0; MemReadE = 1'b0; PCSrcE = 1'b0;
    rdM = 5'd0; RegWriteM = 1'b0; rdW = 5'd0; RegWriteW = 1'b0;
    mem_reqM = 1'b0; mem_readyM = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    zero_inputs();
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    exp_sc = '0;
    exp_fc = '0;
  endtask

  // driver: one vector per cycle, expected response queued with it
  task automatic vec(input logic [4:0] r1d, input logic [4:0] r2d,
                     input logic [4:0] r1e, input logic [4:0] r2e,
                     input logic [4:0] rde, input logic rwe, input logic mre, input logic pcs,
                     input logic [4:0] rdm, input logic rwm,
                     input logic [4:0] rdw, input logic rww,
                     input logic req, input logic rdy,
                     input logic [6:0] ectrl, input logic [1:0] ea, input logic [1:0] eb,
                     input logic eto);
    @(posedge clk); #1;
    rs1_addrD = r1d; rs2_addrD = r2d; rs1_addrE = r1e; rs2_addrE = r2e;
    rdE = rde; RegWriteE = rwe; MemReadE = mre; PCSrcE = pcs;
    rdM = rdm; RegWriteM = rwm; rdW = rdw; RegWriteW = rww;
    mem_reqM = req; mem_readyM = rdy;
    exp_q.push_back({ectrl, ea, eb, eto, exp_sc, exp_fc});
    if (ectrl[6] && exp_sc != {CNT_W{1'b1}}) exp_sc = exp_sc + 1'b1;
    if (ectrl[3] && exp_fc != {CNT_W{1'b1}}) exp_fc = exp_fc + 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {StallF, StallD, FlushD, ID_EX_Flush, StallE, StallM, FlushW,
           ForwardAE, ForwardBE, mem_timeout, stall_cycles, flush_count};
      n_vec++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL vec%0d outputs: got ctrl=%b fa=%b fb=%b to=%b sc=%0d fc=%0d, expected ctrl=%b fa=%b fb=%b to=%b sc=%0d fc=%0d",
                 n_vec, a[W-1 -: 7], a[W-8 -: 2], a[W-10 -: 2], a[2*CNT_W], a[2*CNT_W-1 -: CNT_W], a[CNT_W-1:0],
                 e[W-1 -: 7], e[W-8 -: 2], e[W-10 -: 2], e[2*CNT_W], e[2*CNT_W-1 -: CNT_W], e[CNT_W-1:0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    zero_inputs();
    exp_sc = '0;
    exp_fc = '0;
    do_reset(2);

    //   r1d r2d r1e r2e rde  rwE mrE pcs  rdm  rwM  rdw  rwW  req  rdy  ctrl      fa     fb     to
    vec(0,  0,  0,  0,  0,   0,  0,  0,   0,   0,   0,   0,   0,   0,   C_NONE,   2'b00, 2'b00, 0);
    // load-use on rs2, then the load moves to MEM and forwards to B
    vec(1,  5,  0,  0,  5,   1,  1,  0,   0,   0,   0,   0,   0,   0,   C_LU,     2'b00, 2'b00, 0);
    vec(0,  0,  1,  5,  0,   0,  0,  0,   5,   1,   0,   0,   0,   0,   C_NONE,   2'b00, 2'b10, 0);
    // x0 never stalls or forwards
    vec(0,  0,  0,  0,  0,   1,  1,  0,   0,   1,   0,   1,   0,   0,   C_NONE,   2'b00, 2'b00, 0);
    // MEM beats WB, then WB alone, then mixed sources
    vec(0,  0,  7,  7,  0,   0,  0,  0,   7,   1,   7,   1,   0,   0,   C_NONE,   2'b10, 2'b10, 0);
    vec(0,  0,  7,  7,  0,   0,  0,  0,   7,   0,   7,   1,   0,   0,   C_NONE,   2'b01, 2'b01, 0);
    vec(0,  0,  9,  3,  0,   0,  0,  0,   9,   1,   3,   1,   0,   0,   C_NONE,   2'b10, 2'b01, 0);
    // branch wins over load-use
    vec(4,  0,  0,  0,  4,   1,  1,  1,   0,   0,   0,   0,   0,   0,   C_BR,     2'b00, 2'b00, 0);
    // memory wait with a pending branch, twice: the second run would time out if the
    // wait counter failed to clear on the way back to RUN
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++)
        vec(0, 0, 0, 0, 0,   0,  0,  1,   0,   0,   0,   0,   1,   0,   C_FREEZE, 2'b00, 2'b00, 0);
      vec(0,  0,  0,  0,  0,   0,  0,  1,   0,   0,   0,   0,   1,   1,   C_BR,     2'b00, 2'b00, 0);
    end
    // request completing in the same cycle is invisible
    vec(0,  0,  0,  0,  0,   0,  0,  0,   0,   0,   0,   0,   1,   1,   C_NONE,   2'b00, 2'b00, 0);
    // load-use lasts one cycle when the load advances
    vec(0,  6,  0,  0,  6,   1,  1,  0,   0,   0,   0,   0,   0,   0,   C_LU,     2'b00, 2'b00, 0);
    vec(0,  6,  0,  6,  0,   0,  0,  0,   6,   1,   0,   0,   0,   0,   C_NONE,   2'b00, 2'b10, 0);
    // watchdog: four wait cycles, then ERROR holds regardless of inputs
    for (int i = 0; i < 4; i++)
      vec(0,  0,  0,  0,  0,   0,  0,  0,   0,   0,   0,   0,   1,   0,   C_FREEZE, 2'b00, 2'b00, 0);
    for (int i = 0; i < 3; i++)
      vec(0,  0,  0,  0,  0,   0,  0,  0,   0,   0,   0,   0,   1,   0,   C_FREEZE, 2'b00, 2'b00, 1);
    for (int i = 0; i < 12; i++)
      vec(3,  0,  2,  8,  3,   1,  1,  1,   2,   1,   8,   1,   0,   1,   C_FREEZE, 2'b10, 2'b01, 1);
    // reset out of ERROR
    do_reset(1);
    vec(0,  0,  0,  0,  0,   0,  0,  0,   0,   0,   0,   0,   0,   0,   C_NONE,   2'b00, 2'b00, 0);
    vec(0,  2,  0,  0,  2,   1,  1,  0,   0,   0,   0,   0,   0,   0,   C_LU,     2'b00, 2'b00, 0);
    vec(0,  0,  0,  0,  0,   0,  0,  0,   0,   0,   0,   0,   0,   0,   C_NONE,   2'b00, 2'b00, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard scheduler for the 5-stage pipelined core. It drives the stall and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, including the ID_EX flush input that turns the ID/EX stage into a bubble. It produces the EX-stage forwarding selects and sequences data-memory wait states through a small FSM with a timeout watchdog. It also keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEMWAIT cycles before entering ERROR (valid range 1..255)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  core clock
rst  in  1  reset
rs1_addrD  in  5  ID-stage source reg 1
rs2_addrD  in  5  ID-stage source reg 2
rs1_addrE  in  5  EX-stage source reg 1
rs2_addrE  in  5  EX-stage source reg 2
rdE  in  5  EX-stage destination
RegWriteE  in  1  EX instr writes the register file
MemReadE  in  1  EX instr is a load
PCSrcE  in  1  branch/jump taken, resolved in EX
rdM  in  5  MEM-stage destination
RegWriteM  in  1  MEM instr writes the register file
rdW  in  5  WB-stage destination
RegWriteW  in  1  WB instr writes the register file
mem_reqM  in  1  MEM instr accesses data memory
mem_readyM  in  1  data memory completes the access this cycle
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
FlushD  out  1  clear IF/ID
ID_EX_Flush  out  1  bubble into ID/EX (control bits zeroed)
StallE  out  1  hold ID/EX
StallM  out  1  hold EX/MEM
FlushW  out  1  bubble into MEM/WB
ForwardAE  out  2  EX operand A select: 00 regfile, 10 MEM result, 01 WB result
ForwardBE  out  2  EX operand B select, same encoding as ForwardAE
mem_timeout  out  1  sticky watchdog error flag
stall_cycles  out  CNT_W  count of cycles with StallF=1
flush_count  out  CNT_W  count of cycles with ID_EX_Flush=1

Behaviour:
- Single clock domain on clk. Reset is synchronous and active-high: when rst is sampled high at a clk rising edge, all state clears.
- After reset: state=RUN, wait counter=0, mem_timeout=0, stall_cycles=0, flush_count=0.
- All stall, flush and forward outputs are combinational from the inputs and the current state. Each evaluates to 0 under all-zero inputs in RUN.
- Signal definitions:
  - memstall = mem_reqM & ~mem_readyM
  - loaduse = MemReadE & RegWriteE & (rdE!=0) & (rdE==rs1_addrD | rdE==rs2_addrD)
- Priority, highest first: ERROR, memstall, PCSrcE, loaduse.
- ERROR: StallF=StallD=StallE=StallM=FlushW=1. All other stall/flush outputs are 0. The pipeline stays frozen until rst.
- memstall, in RUN or MEMWAIT: StallF=StallD=StallE=StallM=1 and FlushW=1. FlushD=ID_EX_Flush=0. PCSrcE is ignored while EX is frozen; it is re-presented and acted on in the first cycle without memstall.
- PCSrcE, no memstall: FlushD=1, ID_EX_Flush=1, no stalls. A simultaneous loaduse is discarded because the dependent instruction is on the wrong path.
- loaduse only: StallF=StallD=1, ID_EX_Flush=1 for exactly one cycle. The load then advances to MEM, which clears the condition.
- Forwarding, for A (B is identical using rs2_addrE):
  - 10 if RegWriteM & rdM!=0 & rdM==rs1_addrE
  - else 01 if RegWriteW & rdW!=0 & rdW==rs1_addrE
  - else 00
  - MEM takes precedence over WB. Forwarding is evaluated in every state.
- FSM transitions:
  - RUN -> MEMWAIT when memstall. The wait counter loads 1.
  - MEMWAIT -> RUN when mem_readyM. The wait counter clears.
  - MEMWAIT with memstall: the wait counter increments. When the counter equals MEM_TIMEOUT while memstall is still 1, go to ERROR and set mem_timeout=1.
  - ERROR is left only by rst.
- mem_readyM in the same cycle as mem_reqM causes no stall and no state change.
- stall_cycles increments each cycle StallF=1. flush_count increments each cycle ID_EX_Flush=1. Both saturate at all-ones and never wrap.
- rst mid-MEMWAIT or in ERROR returns to RUN with the counters cleared on that edge.

Test Plan:
- Load-use: MemReadE=1, RegWriteE=1, rdE=5, rs2_addrD=5 -> exactly one cycle of StallF=StallD=ID_EX_Flush=1; flush_count 0->1, stall_cycles 0->1.
- rdE=0 load-use and x0 forwarding: rdE=0 with a matching rs1_addrD=0, and rdM=0 with a matching rs1_addrE=0 -> no stall, ForwardAE=00.
- Forward precedence: rdM=rdW=rs1_addrE=7, RegWriteM=RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01.
- Branch vs. load-use in the same cycle: PCSrcE=1 with loaduse true -> FlushD=1, ID_EX_Flush=1, StallF=0.
- Memory wait: mem_reqM=1, mem_readyM=0 for 3 cycles, then 1, with PCSrcE=1 held throughout -> 3 cycles of full stall with FlushW=1. The state returns to RUN, and FlushD fires in the ready cycle and not before.
- Timeout: MEM_TIMEOUT=4, mem_readyM held at 0 -> mem_timeout=1 after the 4th wait cycle, stalls stay asserted indefinitely, and a rst pulse clears everything to the reset values.
